// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
// FSM encoding, reset PC default and the queued {pc, inst} entry.
package fetch_queue_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        KILL  = 2'd2
    } fq_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory request/response, redirect,
// and the valid/ready handshake towards decode.
interface fetch_queue_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_valid, imem_data,
        input  redirect, redirect_pc,
        output out_valid, out_inst, out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_valid, imem_data,
        output redirect, redirect_pc,
        input  out_valid, out_inst, out_pc,
        output out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of {pc, inst} entries for the fetch queue.
// Pointers wrap modulo DEPTH; clear empties it in one cycle.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  fq_entry_t              i_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output fq_entry_t              o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    fq_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns fetch PC, one outstanding imem request, queue to decode.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic          i_clock,
    input  logic          i_reset,
    fetch_queue_if.master io_bus
);

    localparam int AW = $clog2(DEPTH);

    fq_state_e   r_state;
    fq_state_e   w_next;
    logic [31:0] r_pc;
    logic        w_redir;
    logic        w_resp;
    logic        w_req;
    logic        w_push;
    logic        w_pop;
    logic        w_byp;
    logic        w_byp_take;
    logic        w_full;
    logic        w_empty;
    logic [AW:0] w_count;
    fq_entry_t   w_head;
    fq_entry_t   w_wdata;

    assign w_redir = io_bus.redirect;
    assign w_resp  = (r_state == WAIT) && io_bus.imem_valid && !w_redir;
    // Space is reserved at issue: only FETCH requests, WAIT never over-fills.
    assign w_req   = !i_reset && (r_state == FETCH) && !w_full && !w_redir;

`ifdef FETCH_BYPASS_EN
    assign w_byp      = w_resp && w_empty && !i_reset;
    assign w_byp_take = w_byp && io_bus.out_ready;
`else
    assign w_byp      = 1'b0;
    assign w_byp_take = 1'b0;
`endif

    assign w_push  = w_resp && !w_byp_take;
    assign w_pop   = !w_empty && io_bus.out_ready && !w_redir;
    assign w_wdata = '{pc: r_pc, inst: io_bus.imem_data};

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk  (i_clock),
        .i_rst  (i_reset),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_clear(w_redir),
        .i_data (w_wdata),
        .o_full (w_full),
        .o_empty(w_empty),
        .o_count(w_count),
        .o_head (w_head)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= FETCH;
        else         r_state <= w_next;
    end

    // Redirect in WAIT leaves a stale response pending unless it lands now.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            FETCH: if (w_req) w_next = WAIT;
            WAIT: begin
                if (io_bus.imem_valid) w_next = FETCH;
                else if (w_redir)      w_next = KILL;
            end
            KILL:    if (io_bus.imem_valid) w_next = FETCH;
            default: w_next = FETCH;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset)     r_pc <= RESET_PC;
        else if (w_redir) r_pc <= word_align(io_bus.redirect_pc);
        else if (w_resp)  r_pc <= r_pc + 32'd4;
    end

    always_comb begin
        io_bus.imem_req  = w_req;
        io_bus.imem_addr = r_pc;
        io_bus.out_valid = (w_count != '0) || w_byp;
        io_bus.out_pc    = '0;
        io_bus.out_inst  = NOP;
        if (w_byp) begin
            io_bus.out_pc   = r_pc;
            io_bus.out_inst = io_bus.imem_data;
        end else if (!w_empty) begin
            io_bus.out_pc   = w_head.pc;
            io_bus.out_inst = w_head.inst;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus random bench for fetch_queue against a queue-based model.
// Model honours FETCH_BYPASS_EN when the bench is built with it.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0040_0000;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_queue_if bus ();

    fetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(RPC)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int nchk = 0;

    // reference model: queue contents, fetch pc, pending request kind
    ent_t        mq[$];
    logic [31:0] m_pc = RPC;
    int          m_pend = 0;  // 0 none, 1 live, 2 stale
    bit          m_known = 1'b0;

    // memory model
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    int          mem_lat = 1;
    bit          mem_rand = 1'b0;
    bit          mem_keep = 1'b0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_inst, s_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0005;
        return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h1357;
    endfunction

    task automatic check(input string tag, input logic [31:0] o,
                         input logic [31:0] e);
        nchk++;
        assert (o === e) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic cyc(input bit r, input bit rd, input logic [31:0] rpc,
                       input bit rdy);
        bit          iv, acc, byp, e_req, e_valid;
        logic [31:0] idata, e_pc, e_inst;
        iv = mem_busy && (mem_cnt == 0);
        if (mem_busy && mem_cnt > 0) mem_cnt--;
        idata = iv ? mem_word(mem_addr) : $urandom;
        rst = r;
        bus.redirect    = rd;
        bus.redirect_pc = rd ? rpc : $urandom;
        bus.out_ready   = rdy;
        bus.imem_valid  = iv;
        bus.imem_data   = idata;
        #1;
        acc = !r && (m_pend == 1) && iv && !rd;
        byp = BYP && acc && (mq.size() == 0);
        e_req   = !r && (m_pend == 0) && (mq.size() < DEPTH) && !rd;
        e_valid = (mq.size() != 0) || byp;
        e_pc    = '0;
        e_inst  = '0;
        if (byp) begin
            e_pc   = m_pc;
            e_inst = idata;
        end else if (mq.size() != 0) begin
            e_pc   = mq[0].pc;
            e_inst = mq[0].inst;
        end
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = bus.out_valid;
        s_inst  = bus.out_inst;
        s_pc    = bus.out_pc;
        if (m_known) begin
            check("imem_req", s_req, e_req);
            check("imem_addr", s_addr, m_pc);
            check("out_valid", s_valid, e_valid);
            check("out_inst", s_inst, e_inst);
            check("out_pc", s_pc, e_pc);
        end
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_pc    = RPC;
            m_pend  = 0;
            m_known = 1'b1;
        end else if (rd) begin
            mq.delete();
            if (m_pend == 1)           m_pend = iv ? 0 : 2;
            else if (m_pend == 2 && iv) m_pend = 0;
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (acc) begin
                if (!(byp && rdy)) mq.push_back('{pc: m_pc, inst: idata});
                m_pc   = m_pc + 32'd4;
                m_pend = 0;
            end else if (m_pend == 2 && iv) begin
                m_pend = 0;
            end
            if (e_req) m_pend = 1;
        end
        if (iv) mem_busy = 1'b0;
        if (r && !mem_keep) mem_busy = 1'b0;
        if (s_req === 1'b1) begin
            mem_busy = 1'b1;
            mem_addr = s_addr;
            mem_cnt  = (mem_rand ? int'($urandom_range(1, 3)) : mem_lat) - 1;
        end
        @(negedge clk);
    endtask

    initial begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b0;
        bus.imem_valid  = 1'b0;
        bus.imem_data   = '0;

        // first fetch and latency
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check("t1_req", s_req, 1);
        check("t1_addr", s_addr, RPC);
        cyc(0, 0, 0, 1);
        check("t1_c1_valid", s_valid, BYP);
        if (!BYP) cyc(0, 0, 0, 1);
        check("t1_valid", s_valid, 1);
        check("t1_pc", s_pc, RPC);
        check("t1_inst", s_inst, 32'h2008_0005);
        cyc(0, 0, 0, 1);
        check("t1_next_addr", s_addr, 32'h0040_0004);
        check("t1_drained", s_valid, 0);

        // fill to DEPTH, then drain in order
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (20) cyc(0, 0, 0, 0);
        check("t2_req_full", s_req, 0);
        check("t2_valid", s_valid, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1);
            check($sformatf("t2_drain%0d", i), s_pc, RPC + 32'(4 * i));
        end

        // redirect in WAIT, stale response two cycles later
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        mem_lat = 3;
        cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h0040_0103, 1);
        check("t3_redir_req", s_req, 0);
        cyc(0, 0, 0, 1);
        check("t3_kill_req", s_req, 0);
        mem_lat = 1;
        cyc(0, 0, 0, 1);
        check("t3_stale_valid", s_valid, 0);
        cyc(0, 0, 0, 1);
        check("t3_new_req", s_req, 1);
        check("t3_new_addr", s_addr, 32'h0040_0100);
        cyc(0, 0, 0, 1);
        if (!BYP) cyc(0, 0, 0, 1);
        check("t3_first_valid", s_valid, 1);
        check("t3_first_pc", s_pc, 32'h0040_0100);

        // redirect with imem_valid and out_ready, two entries queued
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h0040_0200, 1);
        check("t4_pre_valid", s_valid, 1);
        check("t4_pre_pc", s_pc, RPC);
        cyc(0, 0, 0, 0);
        check("t4_valid", s_valid, 0);
        check("t4_req", s_req, 1);
        check("t4_addr", s_addr, 32'h0040_0200);

        // reset mid-WAIT, late response after reset release
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        mem_lat  = 4;
        mem_keep = 1'b1;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        mem_lat = 1;
        cyc(0, 0, 0, 1);
        mem_keep = 1'b0;
        check("t5_req", s_req, 1);
        check("t5_addr", s_addr, RPC);
        check("t5_valid", s_valid, 0);
        cyc(0, 0, 0, 1);
        if (!BYP) cyc(0, 0, 0, 1);
        check("t5_pc", s_pc, RPC);
        check("t5_inst", s_inst, 32'h2008_0005);

        // redirect in FETCH near the top of memory, pc wraps to 0
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 32'hFFFF_FFFA, 0);
        check("t6_redir_req", s_req, 0);
        repeat (12) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        check("t6_pc0", s_pc, 32'hFFFF_FFF8);
        cyc(0, 0, 0, 1);
        check("t6_pc1", s_pc, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 1);
        check("t6_pc2", s_pc, 32'h0000_0000);
        cyc(0, 0, 0, 1);
        check("t6_pc3", s_pc, 32'h0000_0004);

        // random traffic against the model
        mem_rand = 1'b1;
        repeat (800) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                $urandom, $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly upstream of the control/decode logic.
- Owns the fetch PC and issues one word request at a time to instruction memory.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Flushes and refetches on a redirect (jump, JR, taken branch) from downstream.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 32'h00400000, first fetch address after reset.

Ports:
- clock, input, 1, single clock; all state updates on posedge.
- reset, input, 1, synchronous, active-high.
- imem_req, output, 1, request strobe; memory samples imem_addr on a posedge where imem_req=1.
- imem_addr, output, 32, word-aligned fetch address; equals fetch_pc.
- imem_valid, input, 1, response strobe; at least 1 cycle after the request; one per request.
- imem_data, input, 32, instruction word; valid when imem_valid=1.
- redirect, input, 1, flush the queue and restart fetch at redirect_pc.
- redirect_pc, input, 32, new fetch address; bits [1:0] ignored and forced to 0.
- out_valid, output, 1, head entry available to decode.
- out_inst, output, 32, head instruction.
- out_pc, output, 32, PC of head instruction.
- out_ready, input, 1, decode accepts the head this cycle.

Behaviour:
- Reset (synchronous, active-high; dominates all other inputs):
  - fetch_pc=RESET_PC; queue empty; count=0; state=FETCH.
  - out_valid=0, out_inst=0, out_pc=0, imem_req=0.
- At most one request is outstanding.
- FSM states: FETCH, WAIT, KILL.
  - FETCH: imem_req = (count<DEPTH) && !redirect. When a request is issued, go to WAIT.
  - WAIT: imem_req=0. On imem_valid with no redirect: push {fetch_pc, imem_data}, fetch_pc += 4, go to FETCH.
  - WAIT with redirect (including the same cycle as imem_valid): response is discarded. If imem_valid also arrives that cycle, go to FETCH; otherwise go to KILL.
  - KILL: wait for the stale response, discard it, go to FETCH. A further redirect while in KILL only updates fetch_pc.
- Any redirect, in any state:
  - fetch_pc = {redirect_pc[31:2], 2'b00} and the queue is cleared.
  - A redirect dominates a same-cycle dequeue and a same-cycle push.
- Output:
  - out_valid = (count != 0).
  - out_inst/out_pc show the head entry; both are 0 when the queue is empty.
  - Dequeue on out_valid && out_ready && !redirect.
- Full/empty:
  - Push and pop in the same cycle keep count unchanged.
  - No request is issued while count==DEPTH.
  - Space is reserved at issue, so a response can never overflow: issue only if count + in_flight < DEPTH.
- Pointers wrap modulo DEPTH.
- fetch_pc + 4 wraps 32'hFFFFFFFC -> 32'h00000000.
- Latency, no bypass: reset released at cycle 0 gives imem_req at cycle 0. With a 1-cycle memory, imem_valid comes at cycle 1 and out_valid at cycle 2. Steady-state throughput is one instruction per 2 cycles.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - When the queue is empty, in WAIT, imem_valid=1 and no redirect, the response drives out_valid/out_inst/out_pc combinationally in the same cycle.
  - If out_ready=1 it is consumed and never written to the queue; otherwise it is pushed as normal.
- Undefined: no combinational path from imem_* to out_*; minimum latency is as stated above.

Decomposition:
- Shared header constants:
  - RESET_PC default value.
  - FSM encodings FETCH=2'd0, WAIT=2'd1, KILL=2'd2.
  - NOP encoding 32'h00000000.
- Natural sub-module: fetch_fifo.
  - Parameterised by DEPTH; stores 64-bit {pc, inst}.
  - Ports: push, pop, clear, full, empty, count, head.
  - The FSM and fetch_pc stay in fetch_queue.

Test Plan:
- Reset then 1-cycle memory returning 32'h20080005 at 0x00400000, out_ready=1 -> out_valid at cycle 2 with out_pc=0x00400000, out_inst=32'h20080005; next imem_addr=0x00400004.
- out_ready=0 for 20 cycles -> exactly 4 entries (PCs 0x00400000..0x0040000C); imem_req stays 0 once count+in_flight=4; raising out_ready drains them in order.
- Redirect to 0x00400103 while in WAIT, stale response 2 cycles later -> stale word dropped, queue empty; next imem_addr=0x00400100; first out_pc=0x00400100.
- Redirect in the same cycle as imem_valid and out_ready with 2 entries queued -> queue empty next cycle, no push, state FETCH, imem_addr=redirect_pc.
- Reset asserted mid-WAIT, late response arriving after reset -> response ignored; out_valid=0; first request after reset is RESET_PC.
- FETCH_BYPASS_EN defined, empty queue, 1-cycle memory, out_ready=1 -> out_valid in the same cycle as imem_valid; count stays 0.
